// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I datapath: memory handshake with timeout and illegal-opcode trap.
// Define MULDIV_EN to route M-extension R-type instructions through the EXECM wait state.
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic       funct7_b0,
  input  logic       take_branch,
  input  logic       mem_ready,
  input  logic       muldiv_done,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       muldiv_start,
  output logic       illegal_instr,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LINK     = 4'd12,
    S_LUI      = 4'd13,
    S_EXECM    = 4'd14,
    S_TRAP     = 4'd15
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_wait;
  logic             timeout_hit;

  // A cycle spent in a memory-waiting state without completion.
  assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE))
                    && !mem_ready;
  assign timeout_hit = (MEM_TIMEOUT != 0) && mem_wait
                       && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R: begin
`ifdef MULDIV_EN
            state_d = funct7_b0 ? S_EXECM : S_EXECR;
`else
            state_d = funct7_b0 ? S_TRAP : S_EXECR;
`endif
          end
          OP_I:      state_d = S_EXECI;
          OP_BRANCH: state_d = S_BRANCH;
          OP_JAL:    state_d = S_JAL;
          OP_JALR:   state_d = S_JALR;
          OP_LUI:    state_d = S_LUI;
          OP_AUIPC:  state_d = S_ALUWB;
          default:   state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR:     state_d = S_LINK;
      S_LINK:     state_d = S_ALUWB;
      S_LUI:      state_d = S_ALUWB;
      S_EXECM: begin
`ifdef MULDIV_EN
        if (muldiv_done) state_d = S_ALUWB;
`else
        state_d = S_TRAP;
`endif
      end
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
    if (timeout_hit) state_d = S_TRAP;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if (mem_wait)      cnt_d = cnt_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MULDIV_EN
  logic execm_seen_q;

  always_ff @(posedge clk) begin
    if (!reset_n) execm_seen_q <= 1'b0;
    else          execm_seen_q <= (state_q == S_EXECM);
  end

  assign muldiv_start = reset_n && (state_q == S_EXECM) && !execm_seen_q;
`else
  logic unused_muldiv;
  assign unused_muldiv = &{1'b0, muldiv_done};
  assign muldiv_start  = 1'b0;
`endif

  always_comb begin
    PCWrite       = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    MemWrite      = 1'b0;
    AdrSrc        = 1'b0;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ResultSrc     = 2'b00;
    ALUOp         = 2'b00;
    illegal_instr = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR, S_EXECM: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB:    RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        PCWrite = take_branch;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      S_JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      S_LINK: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
      end
      S_TRAP:     illegal_instr = 1'b1;
      default:    illegal_instr = 1'b1;
    endcase
    // Write strobes must never fire while the core is held in reset.
    if (!reset_n) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end
  end

  always_comb begin
    ImmSrc = 3'b000;
    unique case (opcode)
      OP_STORE:          ImmSrc = 3'b001;
      OP_BRANCH:         ImmSrc = 3'b010;
      OP_JAL:            ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC:  ImmSrc = 3'b100;
      default:           ImmSrc = 3'b000;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: stimulus queues per-cycle expected outputs, a negedge monitor compares.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] opcode;
  logic       funct7_b0, take_branch, mem_ready, muldiv_done;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp;
  logic [2:0] ImmSrc;
  logic       muldiv_start, illegal_instr;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct7_b0(funct7_b0),
    .take_branch(take_branch), .mem_ready(mem_ready), .muldiv_done(muldiv_done),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUOp(ALUOp), .ImmSrc(ImmSrc), .muldiv_start(muldiv_start),
    .illegal_instr(illegal_instr), .state_o(state_o)
  );

  // Observation word: {state, PCWrite IRWrite RegWrite MemWrite, AdrSrc A B ResultSrc ALUOp, ImmSrc, muldiv_start illegal}
  typedef logic [21:0] obs_t;

  // Datapath selects per state: {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp}
  localparam logic [8:0] M_FETCH  = 9'b0_00_10_10_00;
  localparam logic [8:0] M_DECODE = 9'b0_01_01_00_00;
  localparam logic [8:0] M_MEMADR = 9'b0_10_01_00_00;
  localparam logic [8:0] M_MEM    = 9'b1_00_00_00_00;
  localparam logic [8:0] M_MEMWB  = 9'b0_00_00_01_00;
  localparam logic [8:0] M_EXECR  = 9'b0_10_00_00_10;
  localparam logic [8:0] M_EXECI  = 9'b0_10_01_00_10;
  localparam logic [8:0] M_ZERO   = 9'b0_00_00_00_00;
  localparam logic [8:0] M_BR     = 9'b0_10_00_00_01;
  localparam logic [8:0] M_JAL    = 9'b0_01_10_00_00;
  localparam logic [8:0] M_JALR   = 9'b0_10_01_10_00;
  localparam logic [8:0] M_LUI    = 9'b0_11_01_00_00;

  obs_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [2:0] exp_imm;

  always @(negedge clk) begin
    obs_t exp_v;
    obs_t act_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {state_o, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
               ResultSrc, ALUOp, ImmSrc, muldiv_start, illegal_instr};
      n_checks++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL cycle_check #%0d @%0t: got state=%0d obs=%b, expected state=%0d obs=%b",
                 n_checks, $time, act_v[21:18], act_v, exp_v[21:18], exp_v);
      end
    end
  end

  task automatic instr(input logic [6:0] op, input logic f7, input logic [2:0] imm);
    opcode    = op;
    funct7_b0 = f7;
    exp_imm   = imm;
  endtask

  task automatic step(input logic rdy, input logic tkb, input logic mdone,
                      input logic [3:0] st, input logic [3:0] strb,
                      input logic [8:0] mux, input logic [1:0] misc);
    mem_ready   = rdy;
    take_branch = tkb;
    muldiv_done = mdone;
    exp_q.push_back({st, strb, mux, exp_imm, misc});
    @(posedge clk);
    #1;
  endtask

  task automatic fetch();
    step(1'b1, 1'b0, 1'b0, 4'd0, 4'b1100, M_FETCH, 2'b00);
  endtask

  task automatic decode();
    step(1'b1, 1'b0, 1'b0, 4'd1, 4'b0000, M_DECODE, 2'b00);
  endtask

  task automatic trap_reset();
    reset_n = 1'b0;
    step(1'b1, 1'b0, 1'b0, 4'd15, 4'b0000, M_ZERO, 2'b01);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    mem_ready = 1'b1; take_branch = 1'b0; muldiv_done = 1'b0;
    instr(7'b0000011, 1'b0, 3'b000);
    @(posedge clk);
    #1;
    // Held in reset with mem_ready high: FETCH, strobes suppressed.
    step(1'b1, 1'b0, 1'b0, 4'd0, 4'b0000, M_FETCH, 2'b00);
    reset_n = 1'b1;

    // Load, no waits: 0,1,2,3,4
    fetch(); decode();
    step(1'b1, 1'b0, 1'b0, 4'd2, 4'b0000, M_MEMADR, 2'b00);
    step(1'b1, 1'b0, 1'b0, 4'd3, 4'b0000, M_MEM,    2'b00);
    step(1'b1, 1'b0, 1'b0, 4'd4, 4'b0010, M_MEMWB,  2'b00);

    // Store with three wait cycles: MemWrite high for four cycles
    instr(7'b0100011, 1'b0, 3'b001);
    fetch(); decode();
    step(1'b1, 1'b0, 1'b0, 4'd2, 4'b0000, M_MEMADR, 2'b00);
    repeat (3) step(1'b0, 1'b0, 1'b0, 4'd5, 4'b0001, M_MEM, 2'b00);
    step(1'b1, 1'b0, 1'b0, 4'd5, 4'b0001, M_MEM, 2'b00);

    // Load with one FETCH wait and two MEMREAD waits
    instr(7'b0000011, 1'b0, 3'b000);
    step(1'b0, 1'b0, 1'b0, 4'd0, 4'b0000, M_FETCH, 2'b00);
    fetch(); decode();
    step(1'b1, 1'b0, 1'b0, 4'd2, 4'b0000, M_MEMADR, 2'b00);
    repeat (2) step(1'b0, 1'b0, 1'b0, 4'd3, 4'b0000, M_MEM, 2'b00);
    step(1'b1, 1'b0, 1'b0, 4'd3, 4'b0000, M_MEM,   2'b00);
    step(1'b1, 1'b0, 1'b0, 4'd4, 4'b0010, M_MEMWB, 2'b00);

    // BEQ taken, then not taken
    instr(7'b1100011, 1'b0, 3'b010);
    fetch(); decode();
    step(1'b1, 1'b1, 1'b0, 4'd9, 4'b1000, M_BR, 2'b00);
    fetch(); decode();
    step(1'b1, 1'b0, 1'b0, 4'd9, 4'b0000, M_BR, 2'b00);

    // JALR: 0,1,11,12,8
    instr(7'b1100111, 1'b0, 3'b000);
    fetch(); decode();
    step(1'b1, 1'b0, 1'b0, 4'd11, 4'b1000, M_JALR, 2'b00);
    step(1'b1, 1'b0, 1'b0, 4'd12, 4'b0000, M_JAL,  2'b00);
    step(1'b1, 1'b0, 1'b0, 4'd8,  4'b0010, M_ZERO, 2'b00);

    // R-type, I-type, JAL, LUI, AUIPC
    instr(7'b0110011, 1'b0, 3'b000);
    fetch(); decode();
    step(1'b1, 1'b0, 1'b0, 4'd6, 4'b0000, M_EXECR, 2'b00);
    step(1'b1, 1'b0, 1'b0, 4'd8, 4'b0010, M_ZERO,  2'b00);
    instr(7'b0010011, 1'b0, 3'b000);
    fetch(); decode();
    step(1'b1, 1'b0, 1'b0, 4'd7, 4'b0000, M_EXECI, 2'b00);
    step(1'b1, 1'b0, 1'b0, 4'd8, 4'b0010, M_ZERO,  2'b00);
    instr(7'b1101111, 1'b0, 3'b011);
    fetch(); decode();
    step(1'b1, 1'b0, 1'b0, 4'd10, 4'b1000, M_JAL,  2'b00);
    step(1'b1, 1'b0, 1'b0, 4'd8,  4'b0010, M_ZERO, 2'b00);
    instr(7'b0110111, 1'b0, 3'b100);
    fetch(); decode();
    step(1'b1, 1'b0, 1'b0, 4'd13, 4'b0000, M_LUI,  2'b00);
    step(1'b1, 1'b0, 1'b0, 4'd8,  4'b0010, M_ZERO, 2'b00);
    instr(7'b0010111, 1'b0, 3'b100);
    fetch(); decode();
    step(1'b1, 1'b0, 1'b0, 4'd8, 4'b0010, M_ZERO, 2'b00);

    // Reset in the middle of a store discards it
    instr(7'b0100011, 1'b0, 3'b001);
    fetch(); decode();
    step(1'b1, 1'b0, 1'b0, 4'd2, 4'b0000, M_MEMADR, 2'b00);
    step(1'b0, 1'b0, 1'b0, 4'd5, 4'b0001, M_MEM, 2'b00);
    reset_n = 1'b0;
    step(1'b0, 1'b0, 1'b0, 4'd5, 4'b0000, M_MEM, 2'b00);
    reset_n = 1'b1;
    instr(7'b0010111, 1'b0, 3'b100);
    fetch(); decode();
    step(1'b1, 1'b0, 1'b0, 4'd8, 4'b0010, M_ZERO, 2'b00);

    // MUL (funct7 bit 0 set)
    instr(7'b0110011, 1'b1, 3'b000);
    fetch(); decode();
`ifdef MULDIV_EN
    step(1'b1, 1'b0, 1'b0, 4'd14, 4'b0000, M_EXECR, 2'b10);
    step(1'b1, 1'b0, 1'b0, 4'd14, 4'b0000, M_EXECR, 2'b00);
    step(1'b1, 1'b0, 1'b1, 4'd14, 4'b0000, M_EXECR, 2'b00);
    step(1'b1, 1'b0, 1'b0, 4'd8,  4'b0010, M_ZERO,  2'b00);
`else
    step(1'b1, 1'b0, 1'b1, 4'd15, 4'b0000, M_ZERO, 2'b01);
    trap_reset();
`endif

    // Illegal opcode: sticky TRAP for ten cycles, one reset cycle recovers
    instr(7'b0000000, 1'b0, 3'b000);
    fetch(); decode();
    repeat (10) step(1'b1, 1'b1, 1'b1, 4'd15, 4'b0000, M_ZERO, 2'b01);
    trap_reset();
    instr(7'b0010111, 1'b0, 3'b100);
    fetch(); decode();
    step(1'b1, 1'b0, 1'b0, 4'd8, 4'b0010, M_ZERO, 2'b00);

    // Timeout of 4 while stalled in FETCH
    instr(7'b0000011, 1'b0, 3'b000);
    repeat (4) step(1'b0, 1'b0, 1'b0, 4'd0, 4'b0000, M_FETCH, 2'b00);
    step(1'b0, 1'b0, 1'b0, 4'd15, 4'b0000, M_ZERO, 2'b01);
    trap_reset();
    fetch();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
